output_port_ctrl: RTL and testbench

//  Output-side controller of one router port: the upstream end of the credit link that feeds a

---
 rtl/noc_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/output_port_ctrl.sv | 89 ++++++++
 tb/tb_output_port_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router definitions: port index names and buffer/credit sizing helpers.
// No logic; constants and constant functions only.
// Not applicable (no flow control in a package).
package noc_pkg;

    // Router port indices, used to set PORT_ID on each output port instance
    localparam int PORT_LOCAL = 0;
    localparam int PORT_N     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_W     = 4;
    localparam int PORT_UP    = 5;
    localparam int PORT_DOWN  = 6;

    // Downstream buffer depth for an address width of b bits
    function automatic int depth_of(input int b);
        return 1 << b;
    endfunction

    // Bits needed to hold a credit count in 0..depth_of(b), i.e. b+1
    function automatic int credit_width(input int b);
        return $clog2((1 << b) + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Grant is combinational in the request cycle; pointer moves past the winner on the next edge.
// enable low suppresses the grant and freezes the pointer.
module rr_arbiter #(
    parameter int P = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [P-1:0] req,
    input  logic         enable,
    output logic [P-1:0] grant
);

    localparam int           PW  = (P > 1) ? $clog2(P) : 1;
    localparam logic [P-1:0] ONE = P'(1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW:0]   idx_ext;
    logic          found;

    // Scan from ptr upward with wrap; first set request bit wins
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        idx_ext = '0;
        for (int off = 0; off < P; off++) begin
            idx_ext = {1'b0, ptr_q} + (PW+1)'(off);
            if (idx_ext >= (PW+1)'(P)) begin
                idx_ext = idx_ext - (PW+1)'(P);
            end
            if (!found && req[idx_ext[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = idx_ext[PW-1:0];
            end
        end
        grant = (enable && found) ? (ONE << win_idx) : '0;
        ptr_d = ptr_q;
        if (enable && found) begin
            ptr_d = (win_idx == PW'(P-1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Pointer register; reset starts the search at requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_port_ctrl.sv
// Output port controller: arbitrates inputs for this output, drives the credit link downstream.
// Grant same cycle as request; flit appears on the link one cycle after its grant.
// No grant while credits are zero; downstream flit_rel pulses refill credits.
module output_port_ctrl
    import noc_pkg::*;
#(
    parameter int FW      = 64,
    parameter int P       = 7,
    parameter int B       = 4,
    parameter int PORT_ID = PORT_LOCAL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [P-1:0]  req_in,
    output logic [P-1:0]  grant_out,
    input  logic [FW-1:0] flit_from_xbar,
    output logic          flit_out_wr,
    output logic [FW-1:0] flit_out,
    input  logic          credit_in,
    output logic [B:0]    credit_cnt,
    output logic          credit_err
);

    localparam logic [B:0]   DEPTH_C   = (B+1)'(depth_of(B));
    localparam logic [P-1:0] SELF_MASK = P'(1) << PORT_ID;

    logic [P-1:0]  eligible;
    logic          credit_ok;
    logic          grant_vld;

    logic [B:0]    credit_q, credit_d;
    logic          err_q, err_d;
    logic          flit_wr_q, flit_wr_d;
    logic [FW-1:0] flit_q, flit_d;

    // A port never routes back to itself, and nothing is granted without a downstream slot
    assign eligible  = req_in & ~SELF_MASK;
    assign credit_ok = (credit_q != '0);

    rr_arbiter #(.P(P)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (eligible),
        .enable (credit_ok),
        .grant  (grant_out)
    );

    assign grant_vld = |grant_out;

    // Credit accounting and link register next-state
    always_comb begin
        credit_d  = credit_q;
        err_d     = err_q;
        flit_wr_d = grant_vld;
        flit_d    = grant_vld ? flit_from_xbar : flit_q;
        unique case ({grant_vld, credit_in})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == DEPTH_C) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // State registers; reset drops any in-flight write and refills credits to full depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q  <= DEPTH_C;
            err_q     <= 1'b0;
            flit_wr_q <= 1'b0;
            flit_q    <= '0;
        end else begin
            credit_q  <= credit_d;
            err_q     <= err_d;
            flit_wr_q <= flit_wr_d;
            flit_q    <= flit_d;
        end
    end

    assign credit_cnt  = credit_q;
    assign credit_err  = err_q;
    assign flit_out_wr = flit_wr_q;
    assign flit_out    = flit_q;

endmodule

// File: tb/tb_output_port_ctrl.sv
// Directed bench for output_port_ctrl (P=7, B=4, PORT_ID=0).
// Inputs change 1 time unit after a rising edge; grant is sampled 2 units later,
// registered outputs 1 unit after the following rising edge.
module tb_output_port_ctrl;

    localparam int FW = 64;
    localparam int P  = 7;
    localparam int B  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [P-1:0]  req_in;
    logic [P-1:0]  grant_out;
    logic [FW-1:0] flit_from_xbar;
    logic          flit_out_wr;
    logic [FW-1:0] flit_out;
    logic          credit_in;
    logic [B:0]    credit_cnt;
    logic          credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    output_port_ctrl #(.FW(FW), .P(P), .B(B), .PORT_ID(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_in         (req_in),
        .grant_out      (grant_out),
        .flit_from_xbar (flit_from_xbar),
        .flit_out_wr    (flit_out_wr),
        .flit_out       (flit_out),
        .credit_in      (credit_in),
        .credit_cnt     (credit_cnt),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Return n credits with no requests pending
    task automatic give_credits(input int n);
        req_in = '0;
        for (int i = 0; i < n; i++) begin
            credit_in = 1'b1;
            cyc();
        end
        credit_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '0; credit_in = 1'b0; flit_from_xbar = '0;
        cyc(); cyc();
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_cnt got %0d want 16", credit_cnt); end
        n_checks++; if (grant_out !== 7'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0", grant_out); end
        n_checks++; if (flit_out_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", flit_out_wr); end
        n_checks++; if (flit_out !== 64'h0) begin n_fail++; $display("FAIL reset_flit got %h want 0", flit_out); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", credit_err); end
        rst_n = 1'b1;
        cyc();
        req_in = 7'b0000001;
        #2;
        n_checks++; if (grant_out !== 7'b0) begin n_fail++; $display("FAIL self_mask_grant got %b want 0", grant_out); end
        cyc();
        n_checks++; if (flit_out_wr !== 1'b0) begin n_fail++; $display("FAIL self_mask_wr got %b want 0", flit_out_wr); end
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL self_mask_cnt got %0d want 16", credit_cnt); end
        req_in = '0;
    endtask

    // ptr=0, requesters 2 and 5 alternate; ptr ends at 6
    task automatic test_alternate();
        logic [P-1:0]  exp_g [4];
        logic [FW-1:0] f;
        exp_g[0] = 7'b0000100; exp_g[1] = 7'b0100000;
        exp_g[2] = 7'b0000100; exp_g[3] = 7'b0100000;
        req_in = 7'b0100100;
        for (int i = 0; i < 4; i++) begin
            f = 64'hA5A5_0000_0000_0000 + 64'(i);
            flit_from_xbar = f;
            #2;
            n_checks++; if (grant_out !== exp_g[i]) begin n_fail++; $display("FAIL alt_grant[%0d] got %b want %b", i, grant_out, exp_g[i]); end
            cyc();
            n_checks++; if (flit_out_wr !== 1'b1) begin n_fail++; $display("FAIL alt_wr[%0d] got %b want 1", i, flit_out_wr); end
            n_checks++; if (flit_out !== f) begin n_fail++; $display("FAIL alt_flit[%0d] got %h want %h", i, flit_out, f); end
        end
        req_in = '0;
        cyc();
        n_checks++; if (flit_out_wr !== 1'b0) begin n_fail++; $display("FAIL alt_wr_idle got %b want 0", flit_out_wr); end
        n_checks++; if (flit_out !== 64'hA5A5_0000_0000_0003) begin n_fail++; $display("FAIL alt_flit_hold got %h want a5a5000000000003", flit_out); end
        n_checks++; if (credit_cnt !== 5'd12) begin n_fail++; $display("FAIL alt_cnt got %0d want 12", credit_cnt); end
        give_credits(4);
    endtask

    // Drain all 16 credits with requester 1, then one credit return re-enables one grant
    task automatic test_credit_drain();
        req_in = 7'b0000010;
        for (int i = 0; i < 16; i++) begin
            #2;
            n_checks++; if (grant_out !== 7'b0000010) begin n_fail++; $display("FAIL drain_grant[%0d] got %b want 0000010", i, grant_out); end
            cyc();
            n_checks++; if (credit_cnt !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_cnt[%0d] got %0d want %0d", i, credit_cnt, 15 - i); end
        end
        #2;
        n_checks++; if (grant_out !== 7'b0) begin n_fail++; $display("FAIL empty_grant got %b want 0", grant_out); end
        cyc();
        n_checks++; if (flit_out_wr !== 1'b0) begin n_fail++; $display("FAIL empty_wr got %b want 0", flit_out_wr); end
        credit_in = 1'b1;
        #2;
        n_checks++; if (grant_out !== 7'b0) begin n_fail++; $display("FAIL zero_cnt_credit_grant got %b want 0", grant_out); end
        cyc();
        credit_in = 1'b0;
        n_checks++; if (credit_cnt !== 5'd1) begin n_fail++; $display("FAIL refill_cnt got %0d want 1", credit_cnt); end
        #2;
        n_checks++; if (grant_out !== 7'b0000010) begin n_fail++; $display("FAIL resume_grant got %b want 0000010", grant_out); end
        cyc();
        n_checks++; if (credit_cnt !== 5'd0) begin n_fail++; $display("FAIL resume_cnt got %0d want 0", credit_cnt); end
        give_credits(16);
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL drain_restore got %0d want 16", credit_cnt); end
    endtask

    // Grant and credit in the same cycle cancel; credit at full depth flags a sticky error
    task automatic test_credit_both();
        req_in = 7'b0001000;
        for (int i = 0; i < 11; i++) cyc();
        n_checks++; if (credit_cnt !== 5'd5) begin n_fail++; $display("FAIL both_pre got %0d want 5", credit_cnt); end
        credit_in = 1'b1;
        #2;
        n_checks++; if (grant_out !== 7'b0001000) begin n_fail++; $display("FAIL both_grant got %b want 0001000", grant_out); end
        cyc();
        credit_in = 1'b0;
        n_checks++; if (credit_cnt !== 5'd5) begin n_fail++; $display("FAIL both_cnt got %0d want 5", credit_cnt); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL both_err got %b want 0", credit_err); end
        give_credits(11);
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL full_cnt got %0d want 16", credit_cnt); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL full_err_early got %b want 0", credit_err); end
        give_credits(1);
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL over_cnt got %0d want 16", credit_cnt); end
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL over_err got %b want 1", credit_err); end
        cyc();
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", credit_err); end
    endtask

    // ptr=4 on entry; single grant to 5 moves ptr to 6, then 6 wins before 1 (wrap)
    task automatic test_wrap();
        req_in = 7'b0100000;
        #2;
        n_checks++; if (grant_out !== 7'b0100000) begin n_fail++; $display("FAIL wrap_setup got %b want 0100000", grant_out); end
        cyc();
        req_in = 7'b1000010;
        #2;
        n_checks++; if (grant_out !== 7'b1000000) begin n_fail++; $display("FAIL wrap_first got %b want 1000000", grant_out); end
        cyc();
        req_in = 7'b0000010;
        #2;
        n_checks++; if (grant_out !== 7'b0000010) begin n_fail++; $display("FAIL wrap_second got %b want 0000010", grant_out); end
        cyc();
        give_credits(3);
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL wrap_restore got %0d want 16", credit_cnt); end
    endtask

    // Reset mid-burst: async clear of credits and link write; ptr returns to 0
    task automatic test_back_to_back_reset();
        req_in = 7'b0000100;
        flit_from_xbar = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 13; i++) cyc();
        n_checks++; if (credit_cnt !== 5'd3) begin n_fail++; $display("FAIL mid_cnt got %0d want 3", credit_cnt); end
        n_checks++; if (flit_out_wr !== 1'b1) begin n_fail++; $display("FAIL mid_wr got %b want 1", flit_out_wr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (credit_cnt !== 5'd16) begin n_fail++; $display("FAIL rst_cnt got %0d want 16", credit_cnt); end
        n_checks++; if (flit_out_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr got %b want 0", flit_out_wr); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", credit_err); end
        n_checks++; if (flit_out !== 64'h0) begin n_fail++; $display("FAIL rst_flit got %h want 0", flit_out); end
        req_in = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        // ptr was 3 before reset; from ptr 0 requester 2 must beat requester 3
        req_in = 7'b0001100;
        #2;
        n_checks++; if (grant_out !== 7'b0000100) begin n_fail++; $display("FAIL rst_ptr got %b want 0000100", grant_out); end
        cyc();
        req_in = '0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_credit_drain();
        test_credit_both();
        test_wrap();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
